dmem_access_arbiter: RTL

//  Shares the single-port data memory between the pipeline MEM stage and an external loader/DMA port.

---
 rtl/dmem_access_arbiter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/dmem_access_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_access_arbiter
//
// Purpose:
//   Shares a single-port data memory between the pipeline MEM stage and an
//   external loader/DMA port. Every access is sequenced by a wait-state
//   counter. The pipeline is frozen while one of its accesses is outstanding.
//   pipe_freeze is meant to be ORed into the existing hazard freeze.
//
// Parameters:
//   WORD_W        data and address width
//   WAIT_CYCLES   extra cycles the memory needs per access (0 allowed)
//   STARVE_LIMIT  consecutive pipe grants made while DMA waits before DMA is
//                 forced in (used only with DMEM_STARVE_GUARD_EN)
//
// Configuration macro:
//   DMEM_STARVE_GUARD_EN  defined   -> anti-starvation counter for the DMA port
//                         undefined -> strict pipe priority, no counter
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   pipe_req/we/addr/wdata           MEM-stage request
//   pipe_rdata, pipe_done            load data / final cycle (combinational)
//   pipe_freeze                      pipeline stall (combinational)
//   dma_req/we/addr/wdata            level DMA request, held until dma_ack
//   dma_rdata, dma_ack               registered read data / 1-cycle ack
//   mem_en/we/addr/wdata             registered memory command
//   mem_rdata                        memory read data, valid in final cycle
// -----------------------------------------------------------------------------
module dmem_access_arbiter #(
  parameter int WORD_W       = 32,
  parameter int WAIT_CYCLES  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_req,
  input  logic              pipe_we,
  input  logic [WORD_W-1:0] pipe_addr,
  input  logic [WORD_W-1:0] pipe_wdata,
  output logic [WORD_W-1:0] pipe_rdata,
  output logic              pipe_done,
  output logic              pipe_freeze,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [WORD_W-1:0] dma_addr,
  input  logic [WORD_W-1:0] dma_wdata,
  output logic [WORD_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PIPE = 2'd1,
    DMA  = 2'd2
  } state_t;

  // With WAIT_CYCLES=0 the counter still needs one bit.
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [WORD_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                dma_ack_q, dma_ack_d;
  logic [WORD_W-1:0]   dma_rdata_q, dma_rdata_d;

  logic dma_ok;
  logic force_dma;
  logic grant_pipe;
  logic grant_dma;

  // A DMA request seen in the same cycle as its own ack is the old request
  // still held by the requester; it must not be granted a second time.
  assign dma_ok = dma_req & ~dma_ack_q;

`ifdef DMEM_STARVE_GUARD_EN
  localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

  logic [STV_W-1:0] starve_q, starve_d;

  assign force_dma = (starve_q == STV_MAX) & dma_ok;

  // Counts pipe grants that bypassed a waiting DMA request; saturates at the
  // limit so it holds there until DMA actually gets in.
  always_comb begin
    starve_d = starve_q;
    if (grant_dma) begin
      starve_d = '0;
    end else if (grant_pipe) begin
      if (!dma_req) begin
        starve_d = '0;
      end else if (starve_q != STV_MAX) begin
        starve_d = starve_q + STV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
  assign force_dma = 1'b0;
`endif

  assign grant_pipe = (state_q == IDLE) & pipe_req & ~force_dma;
  assign grant_dma  = (state_q == IDLE) & dma_ok & (~pipe_req | force_dma);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    dma_ack_d   = 1'b0;
    dma_rdata_d = dma_rdata_q;

    case (state_q)
      IDLE: begin
        mem_en_d = 1'b0;
        if (grant_pipe) begin
          mem_en_d    = 1'b1;
          mem_we_d    = pipe_we;
          mem_addr_d  = pipe_addr;
          mem_wdata_d = pipe_wdata;
          cnt_d       = CNT_LOAD;
          state_d     = PIPE;
        end else if (grant_dma) begin
          mem_en_d    = 1'b1;
          mem_we_d    = dma_we;
          mem_addr_d  = dma_addr;
          mem_wdata_d = dma_wdata;
          cnt_d       = CNT_LOAD;
          state_d     = DMA;
        end
      end

      PIPE, DMA: begin
        // mem_* stay put for the whole access; cnt==0 marks the final cycle.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          mem_en_d = 1'b0;
          state_d  = IDLE;
          if (state_q == DMA) begin
            dma_ack_d = 1'b1;
            if (!mem_we_q) begin
              dma_rdata_d = mem_rdata;
            end
          end
        end
      end

      default: begin
        mem_en_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      dma_ack_q   <= 1'b0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      dma_ack_q   <= dma_ack_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // A flushed pipe access (pipe_req dropped mid-access) still completes;
  // the freeze simply follows pipe_req, so the stray pipe_done is harmless.
  assign pipe_done   = (state_q == PIPE) && (cnt_q == '0);
  assign pipe_rdata  = pipe_done ? mem_rdata : '0;
  assign pipe_freeze = pipe_req & ~pipe_done;

  assign dma_rdata = dma_rdata_q;
  assign dma_ack   = dma_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
